// File: rtl/ip_mux_pipe_if.sv
// Handshake and datapath bundle for the registered write-source multiplexer.
// The slave modport is the multiplexer's view; master is the driver's view.
interface ip_mux_pipe_if #(
    parameter int DW = 32,
    parameter int IW = 16
);
    localparam int OW = $clog2(DW / 8);

    logic          in_valid;
    logic          in_ready;
    logic [2:0]    ip_sel;
    logic [1:0]    hl_sel;
    logic [1:0]    ld_size;
    logic          ld_sext;
    logic [OW-1:0] ld_off;
    logic [DW-1:0] rtr_out;
    logic [DW-1:0] alu_out;
    logic [DW-1:0] dib;
    logic [IW-1:0] id_imme;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] mux_out;
    logic          err;
    logic          err_clr;

    modport slave (
        input  in_valid, ip_sel, hl_sel, ld_size, ld_sext, ld_off,
               rtr_out, alu_out, dib, id_imme, out_ready, err_clr,
        output in_ready, out_valid, mux_out, err
    );

    modport master (
        output in_valid, ip_sel, hl_sel, ld_size, ld_sext, ld_off,
               rtr_out, alu_out, dib, id_imme, out_ready, err_clr,
        input  in_ready, out_valid, mux_out, err
    );
endinterface

// File: rtl/ip_mux_pipe.sv
// Register-file write-source multiplexer with load alignment, immediate
// placement, a last-result register for forwarding/high-half merges, and a
// registered output stage backed by a one-entry skid buffer.
module ip_mux_pipe #(
    parameter int DW = 32,
    parameter int IW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    ip_mux_pipe_if.slave   bus
);
    localparam int OW = $clog2(DW / 8);

    logic [DW-1:0] last_r;
    logic [DW-1:0] out_r;
    logic [DW-1:0] skid_r;
    logic          out_valid_r;
    logic          skid_full_r;
    logic          err_r;

    logic          in_ready_s;
    logic          in_fire_s;
    logic          out_fire_s;
    logic [OW-1:0] off_s;
    logic          ld_err_s;
    logic [DW-1:0] lane_s;
    logic [DW-1:0] load_s;
    logic [DW-1:0] imm_zx_s;
    logic [DW-1:0] imm_sx_s;
    logic [DW-1:0] result_s;
    logic          err_s;

    // in_ready comes straight from the skid flag so it is effectively registered
    assign in_ready_s = ~skid_full_r;
    assign in_fire_s  = bus.in_valid & in_ready_s;
    assign out_fire_s = out_valid_r & bus.out_ready;

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.mux_out   = out_r;
    assign bus.err       = err_r;

    assign imm_zx_s = DW'(bus.id_imme);
    assign imm_sx_s = DW'($signed(bus.id_imme));

    // Force the load offset to the size's alignment and flag misalignment
    always_comb begin
        off_s    = bus.ld_off;
        ld_err_s = 1'b0;
        case (bus.ld_size)
            2'b00: begin
                off_s    = bus.ld_off;
                ld_err_s = 1'b0;
            end
            2'b01: begin
                off_s    = bus.ld_off;
                off_s[0] = 1'b0;
                ld_err_s = bus.ld_off[0];
            end
            2'b10: begin
                off_s    = '0;
                ld_err_s = (bus.ld_off != '0);
            end
            default: begin
                // reserved size behaves as a word load
                off_s    = '0;
                ld_err_s = 1'b1;
            end
        endcase
    end

    assign lane_s = bus.dib >> {off_s, 3'b000};

    // Truncate the selected lane to the load size and extend it
    always_comb begin
        load_s = lane_s;
        case (bus.ld_size)
            2'b00: begin
                if (bus.ld_sext) load_s = DW'($signed(lane_s[7:0]));
                else             load_s = DW'(lane_s[7:0]);
            end
            2'b01: begin
                if (bus.ld_sext) load_s = DW'($signed(lane_s[15:0]));
                else             load_s = DW'(lane_s[15:0]);
            end
            default: load_s = lane_s;
        endcase
    end

    // Source selection; illegal selects yield zero and raise an error
    always_comb begin
        result_s = '0;
        err_s    = 1'b0;
        case (bus.ip_sel)
            3'b000: result_s = bus.rtr_out;
            3'b001: result_s = bus.alu_out;
            3'b010: begin
                result_s = load_s;
                err_s    = ld_err_s;
            end
            3'b011: begin
                case (bus.hl_sel)
                    2'b00:   result_s = imm_zx_s;
                    2'b01:   result_s = imm_sx_s;
                    2'b10:   result_s = imm_zx_s << (DW - IW);
                    default: result_s = (imm_zx_s << (DW - IW)) |
                                        (last_r & ({DW{1'b1}} >> IW));
                endcase
            end
            3'b100: result_s = last_r;
            default: begin
                result_s = '0;
                err_s    = 1'b1;
            end
        endcase
    end

    // Last-result register tracks every accepted transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         last_r <= '0;
        else if (in_fire_s) last_r <= result_s;
        else                last_r <= last_r;
    end

    // Sticky error: set on an erroneous accept, set wins over clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  err_r <= 1'b0;
        else if (in_fire_s && err_s) err_r <= 1'b1;
        else if (bus.err_clr)        err_r <= 1'b0;
        else                         err_r <= err_r;
    end

    // Output register plus skid entry, strictly FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r       <= '0;
            out_valid_r <= 1'b0;
            skid_r      <= '0;
            skid_full_r <= 1'b0;
        end else if (out_fire_s || !out_valid_r) begin
            if (skid_full_r) begin
                out_r       <= skid_r;
                out_valid_r <= 1'b1;
                if (in_fire_s) begin
                    skid_r      <= result_s;
                    skid_full_r <= 1'b1;
                end else begin
                    skid_full_r <= 1'b0;
                end
            end else if (in_fire_s) begin
                out_r       <= result_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (in_fire_s) begin
            skid_r      <= result_s;
            skid_full_r <= 1'b1;
        end else begin
            skid_full_r <= skid_full_r;
        end
    end
endmodule
